// File: rtl/seg_scan.sv
// Multiplexed 7-segment display scanner: hex decode, leading-zero blanking, PWM
// brightness and frame-synchronous double buffering of the displayed value.
module seg_scan #(
   parameter int DIGITS     = 4,
   parameter int DIV        = 18,
   parameter bit ACTIVE_LOW = 1'b1
) (
   input  logic                clk,
   input  logic                clr,
   input  logic [4*DIGITS-1:0] data,
   input  logic [DIGITS-1:0]   dp_in,
   input  logic                load,
   input  logic                lz_en,
   input  logic [3:0]          bright,
   output logic [DIGITS-1:0]   an,
   output logic [6:0]          seg,
   output logic                dp,
   output logic                frame
);

   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [IW-1:0] LAST = IW'(DIGITS - 1);

   localparam logic [DIGITS-1:0] AN_OFF  = {DIGITS{ACTIVE_LOW}};
   localparam logic [6:0]        SEG_OFF = {7{ACTIVE_LOW}};

   // Active-high segment pattern {g,f,e,d,c,b,a} for one hex nibble.
   function automatic logic [6:0] hex7(input logic [3:0] n);
      logic [6:0] s;
      case (n)
         4'h0:    s = 7'b0111111;
         4'h1:    s = 7'b0000110;
         4'h2:    s = 7'b1011011;
         4'h3:    s = 7'b1001111;
         4'h4:    s = 7'b1100110;
         4'h5:    s = 7'b1101101;
         4'h6:    s = 7'b1111101;
         4'h7:    s = 7'b0000111;
         4'h8:    s = 7'b1111111;
         4'h9:    s = 7'b1101111;
         4'hA:    s = 7'b1110111;
         4'hB:    s = 7'b1111100;
         4'hC:    s = 7'b0111001;
         4'hD:    s = 7'b1011110;
         4'hE:    s = 7'b1111001;
         default: s = 7'b1110001;
      endcase
      return s;
   endfunction

   // Bit k set when digit k and every digit above it hold zero; digit 0 is never flagged.
   function automatic logic [DIGITS-1:0] lz_mask(input logic [4*DIGITS-1:0] d);
      logic [DIGITS-1:0] m;
      logic              zero_above;
      m          = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above & (d[4*k +: 4] == 4'h0);
         m[k]       = zero_above;
      end
      return m;
   endfunction

   logic [DIV-1:0]      psc;
   logic [IW-1:0]       idx;
   logic [4*DIGITS-1:0] pend_data;
   logic [4*DIGITS-1:0] shd_data;
   logic [DIGITS-1:0]   pend_dp;
   logic [DIGITS-1:0]   shd_dp;
   logic                tick;
   logic                wrap;

   assign tick = &psc;
   assign wrap = tick & (idx == LAST);

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         psc       <= '0;
         idx       <= '0;
         pend_data <= '0;
         pend_dp   <= '0;
         shd_data  <= '0;
         shd_dp    <= '0;
      end else begin
         psc <= psc + 1'b1;
         if (tick)
            idx <= (idx == LAST) ? '0 : idx + 1'b1;
         if (load) begin
            pend_data <= data;
            pend_dp   <= dp_in;
         end
         // Nonblocking read gives the pre-edge pending value when load and wrap coincide.
         if (wrap) begin
            shd_data <= pend_data;
            shd_dp   <= pend_dp;
         end
      end
   end

   // ---- stage p0: digit select, blanking and PWM decision ----
   logic [DIGITS-1:0] sel_p0;
   logic [DIGITS-1:0] lz_p0;
   logic [3:0]        nib_p0;
   logic              dpb_p0;
   logic              sup_p0;
   logic              pwm_p0;
   logic              on_p0;

   always_comb begin
      sel_p0 = '0;
      nib_p0 = 4'h0;
      dpb_p0 = 1'b0;
      sup_p0 = 1'b0;
      lz_p0  = lz_mask(shd_data);
      for (int k = 0; k < DIGITS; k++) begin
         if (idx == IW'(k)) begin
            sel_p0[k] = 1'b1;
            nib_p0    = shd_data[4*k +: 4];
            dpb_p0    = shd_dp[k];
            sup_p0    = lz_en & lz_p0[k];
         end
      end
      pwm_p0 = (psc[DIV-1 -: 4] < bright);
      // A suppressed digit stays lit only to show its decimal point.
      on_p0  = pwm_p0 & (~sup_p0 | dpb_p0);
   end

   // ---- stage p1: registered, polarity-adjusted outputs ----
   logic [DIGITS-1:0] an_p1;
   logic [6:0]        seg_p1;
   logic              dp_p1;
   logic              frame_p1;

   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         an_p1    <= AN_OFF;
         seg_p1   <= SEG_OFF;
         dp_p1    <= ACTIVE_LOW;
         frame_p1 <= 1'b0;
      end else begin
         an_p1    <= on_p0 ? (sel_p0 ^ AN_OFF) : AN_OFF;
         seg_p1   <= (on_p0 & ~sup_p0) ? (hex7(nib_p0) ^ SEG_OFF) : SEG_OFF;
         dp_p1    <= (on_p0 & dpb_p0) ^ ACTIVE_LOW;
         frame_p1 <= wrap;
      end
   end

   assign an    = an_p1;
   assign seg   = seg_p1;
   assign dp    = dp_p1;
   assign frame = frame_p1;

endmodule
